// File: rtl/ttpu_pkg.sv
// Shared types and sizing helpers for the convolution tile scheduler.
// The helpers size address and kernel-dimension fields from the image geometry.
package ttpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STEP,
        DRAIN,
        WRITE,
        FINISH
    } conv_state_t;

    function automatic int unsigned addr_width(input int unsigned w, input int unsigned h);
        return (w * h > 1) ? $clog2(w * h) : 1;
    endfunction

    function automatic int unsigned kdim_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/raster_pos_counter.sv
// Per-unit raster position (row, col, output index, window address) for one compute unit.
// Positions are chained: each unit's next position is one raster step past its predecessor.
module raster_pos_counter #(
    parameter int unsigned AW = 6,
    parameter int unsigned KW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          first,
    input  logic [AW-1:0] ow,
    input  logic [AW-1:0] oh,
    input  logic [KW-1:0] k,
    input  logic [AW-1:0] prev_row,
    input  logic [AW-1:0] prev_col,
    input  logic [AW-1:0] prev_idx,
    input  logic [AW-1:0] prev_addr,
    output logic [AW-1:0] row,
    output logic [AW-1:0] col,
    output logic [AW-1:0] idx,
    output logic [AW-1:0] addr,
    output logic          valid,
    output logic [AW-1:0] nxt_row,
    output logic [AW-1:0] nxt_col,
    output logic [AW-1:0] nxt_idx,
    output logic [AW-1:0] nxt_addr,
    output logic          nxt_valid
);

    always_comb begin
        nxt_row  = '0;
        nxt_col  = '0;
        nxt_idx  = '0;
        nxt_addr = '0;
        if (!first) begin
            nxt_idx = prev_idx + AW'(1);
            if (prev_col == ow - AW'(1)) begin
                nxt_row  = prev_row + AW'(1);
                nxt_col  = '0;
                // Wrapping skips the K-1 columns where no window can start.
                nxt_addr = prev_addr + AW'(k);
            end else begin
                nxt_row  = prev_row;
                nxt_col  = prev_col + AW'(1);
                nxt_addr = prev_addr + AW'(1);
            end
        end
    end

    // Column never exceeds OW-1, so the index is in range exactly when the row is.
    assign nxt_valid = (nxt_row < oh);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row   <= '0;
            col   <= '0;
            idx   <= '0;
            addr  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            row   <= nxt_row;
            col   <= nxt_col;
            idx   <= nxt_idx;
            addr  <= nxt_addr;
            valid <= nxt_valid;
        end
    end

endmodule

// File: rtl/conv_scheduler.sv
// Convolution pass scheduler: walks output pixels in groups of NUM_UNITS and sequences
// load / K*K tap steps / MAC drain / write-back for each group.
module conv_scheduler
    import ttpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned IMAGE_WIDTH  = 8,
    parameter int unsigned IMAGE_HEIGHT = 8,
    parameter int unsigned NUM_UNITS    = 2,
    parameter int unsigned DRAIN_CYCLES = 2,
    localparam int unsigned AW = addr_width(IMAGE_WIDTH, IMAGE_HEIGHT),
    localparam int unsigned KW = kdim_width(IMAGE_WIDTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [KW-1:0]                kernel_dim,
    output logic                         en,
    output logic                         step,
    output logic                         read_mem1,
    output logic                         read_mem2,
    output logic [NUM_UNITS-1:0][AW-1:0] start_addr_1,
    output logic [NUM_UNITS-1:0][AW-1:0] start_addr_2,
    output logic                         acc_clear,
    output logic                         acc_en,
    output logic                         simple_write,
    output logic [NUM_UNITS-1:0][AW-1:0] simple_write_addr,
    output logic [NUM_UNITS-1:0]         wr_mask,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
    localparam int unsigned TW = (2 * KW > DW) ? 2 * KW : DW;

    if (AW > DATA_WIDTH) begin : g_aw_check
        $error("address width exceeds DATA_WIDTH");
    end

    conv_state_t   state_q, state_d;
    logic [KW-1:0] k_q, k_d, k_cur;
    logic [TW-1:0] tap_q, tap_d, kk;
    logic          err_q, err_d;
    logic          k_ok, pos_load, pos_first, more;
    logic [AW-1:0] ow, oh;

    logic [AW-1:0] u_row [NUM_UNITS];
    logic [AW-1:0] u_col [NUM_UNITS];
    logic [AW-1:0] u_idx [NUM_UNITS];
    logic [AW-1:0] u_addr [NUM_UNITS];
    logic          u_valid [NUM_UNITS];
    logic [AW-1:0] n_row [NUM_UNITS];
    logic [AW-1:0] n_col [NUM_UNITS];
    logic [AW-1:0] n_idx [NUM_UNITS];
    logic [AW-1:0] n_addr [NUM_UNITS];
    logic          n_valid [NUM_UNITS];
    logic [AW-1:0] p_row [NUM_UNITS];
    logic [AW-1:0] p_col [NUM_UNITS];
    logic [AW-1:0] p_idx [NUM_UNITS];
    logic [AW-1:0] p_addr [NUM_UNITS];
    logic          u_first [NUM_UNITS];

    assign k_ok = (kernel_dim != '0) && (32'(kernel_dim) < IMAGE_WIDTH)
                  && (32'(kernel_dim) <= IMAGE_HEIGHT);

    // In IDLE the counters are seeded from the live kernel_dim on the accepting edge.
    assign k_cur     = (state_q == IDLE) ? kernel_dim : k_q;
    assign ow        = AW'(IMAGE_WIDTH) - AW'(k_cur) + AW'(1);
    assign oh        = AW'(IMAGE_HEIGHT) - AW'(k_cur) + AW'(1);
    assign kk        = TW'(k_q) * TW'(k_q);
    assign pos_first = (state_q == IDLE);
    assign more      = n_valid[0];
    assign error     = err_q;

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
        if (i == 0) begin : g_head
            assign p_row[i]   = u_row[NUM_UNITS-1];
            assign p_col[i]   = u_col[NUM_UNITS-1];
            assign p_idx[i]   = u_idx[NUM_UNITS-1];
            assign p_addr[i]  = u_addr[NUM_UNITS-1];
            assign u_first[i] = pos_first;
        end else begin : g_tail
            assign p_row[i]   = n_row[i-1];
            assign p_col[i]   = n_col[i-1];
            assign p_idx[i]   = n_idx[i-1];
            assign p_addr[i]  = n_addr[i-1];
            assign u_first[i] = 1'b0;
        end

        raster_pos_counter #(
            .AW(AW),
            .KW(KW)
        ) u_pos (
            .clk      (clk),
            .reset    (reset),
            .load     (pos_load),
            .first    (u_first[i]),
            .ow       (ow),
            .oh       (oh),
            .k        (k_cur),
            .prev_row (p_row[i]),
            .prev_col (p_col[i]),
            .prev_idx (p_idx[i]),
            .prev_addr(p_addr[i]),
            .row      (u_row[i]),
            .col      (u_col[i]),
            .idx      (u_idx[i]),
            .addr     (u_addr[i]),
            .valid    (u_valid[i]),
            .nxt_row  (n_row[i]),
            .nxt_col  (n_col[i]),
            .nxt_idx  (n_idx[i]),
            .nxt_addr (n_addr[i]),
            .nxt_valid(n_valid[i])
        );

        assign start_addr_1[i]      = u_addr[i];
        assign start_addr_2[i]      = '0;
        assign simple_write_addr[i] = u_idx[i];
        assign wr_mask[i]           = u_valid[i];
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        tap_d        = tap_q;
        err_d        = err_q;
        pos_load     = 1'b0;
        en           = 1'b0;
        step         = 1'b0;
        read_mem1    = 1'b0;
        read_mem2    = 1'b0;
        acc_clear    = 1'b0;
        acc_en       = 1'b0;
        simple_write = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            tap_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (k_ok) begin
                            k_d      = kernel_dim;
                            err_d    = 1'b0;
                            pos_load = 1'b1;
                            state_d  = LOAD;
                        end else begin
                            err_d   = 1'b1;
                            state_d = FINISH;
                        end
                    end
                end
                LOAD: begin
                    en        = 1'b1;
                    read_mem1 = 1'b1;
                    read_mem2 = 1'b1;
                    acc_clear = 1'b1;
                    busy      = 1'b1;
                    tap_d     = '0;
                    state_d   = STEP;
                end
                STEP: begin
                    en     = 1'b1;
                    step   = 1'b1;
                    acc_en = 1'b1;
                    busy   = 1'b1;
                    if (tap_q == kk - TW'(1)) begin
                        tap_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        tap_d = tap_q + TW'(1);
                    end
                end
                DRAIN: begin
                    busy = 1'b1;
                    if (tap_q == TW'(DRAIN_CYCLES - 1)) begin
                        tap_d   = '0;
                        state_d = WRITE;
                    end else begin
                        tap_d = tap_q + TW'(1);
                    end
                end
                WRITE: begin
                    simple_write = 1'b1;
                    busy         = 1'b1;
                    pos_load     = more;
                    state_d      = more ? LOAD : FINISH;
                end
                FINISH: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            tap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tap_q   <= tap_d;
            err_q   <= err_d;
        end
    end

endmodule
